// File: rtl/ws2812b_pkg.sv
// ws2812b_pkg: shared WS2812B register map, status bit positions, 64 MHz timing defaults and receiver FSM states.
package ws2812b_pkg;
  localparam logic [3:0] ADDR_STATUS = 4'd0;
  localparam logic [3:0] ADDR_G      = 4'd1;
  localparam logic [3:0] ADDR_R      = 4'd2;
  localparam logic [3:0] ADDR_B      = 4'd3;
  localparam logic [3:0] ADDR_IDX    = 4'd4;
  localparam logic [3:0] ADDR_COUNT  = 4'd5;
  localparam logic [3:0] DRV_ADDR_CTRL = 4'd0;
  localparam logic [3:0] DRV_ADDR_G    = 4'd1;
  localparam logic [3:0] DRV_ADDR_R    = 4'd2;
  localparam logic [3:0] DRV_ADDR_B    = 4'd3;
  localparam int ST_NEW  = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;
  localparam int ST_BUSY = 3;
  localparam int BIT_THRESH = 38;
  localparam int MIN_HIGH   = 8;
  localparam int RESET_CYC  = 3200;
  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} rx_state_e;
endpackage

// File: rtl/ws2812b_rx_bitdec.sv
// ws2812b_rx_bitdec: samples the line, measures pulse widths and emits decoded bits, glitches and frame ends.
module ws2812b_rx_bitdec
  import ws2812b_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic line_o,
  output logic bit_valid_o,
  output logic bit_val_o,
  output logic glitch_o,
  output logic frame_end_o,
  output logic busy_o
);
  localparam logic [11:0] RST_C = 12'(RESET_CYC);
  localparam logic [8:0] MIN_H = 9'(MIN_HIGH);
  localparam logic [8:0] THR = 9'(BIT_THRESH);
  rx_state_e state_q;
  logic line_q, prev_q, rise, fall;
  logic [11:0] low_q;
  logic [8:0] high_q;
  assign rise = line_q & ~prev_q;
  assign fall = ~line_q & prev_q;
  assign line_o = line_q;
  assign busy_o = state_q == HIGH || state_q == LOW;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SYNC;
      {line_q, prev_q, bit_valid_o, bit_val_o, glitch_o, frame_end_o} <= '0;
      low_q <= '0;
      high_q <= '0;
    end else begin
      line_q <= rx_i;
      prev_q <= line_q;
      bit_valid_o <= 1'b0;
      glitch_o <= 1'b0;
      frame_end_o <= 1'b0;
      case (state_q)
        SYNC: begin
          low_q <= line_q ? '0 : low_q + 12'd1;
          if (!line_q && low_q == RST_C - 12'd1) state_q <= IDLE;
        end
        IDLE: if (rise) begin
          state_q <= HIGH;
          high_q <= 9'd1;
        end
        HIGH: if (fall) begin
          state_q <= LOW;
          low_q <= 12'd1;
          bit_valid_o <= high_q >= MIN_H;
          glitch_o <= high_q < MIN_H;
          bit_val_o <= high_q > THR;
        end else high_q <= &high_q ? high_q : high_q + 9'd1;
        LOW: if (rise) begin
          state_q <= HIGH;
          high_q <= 9'd1;
        end else if (low_q == RST_C) begin
          state_q <= IDLE;
          frame_end_o <= 1'b1;
        end else low_q <= low_q + 12'd1;
        default: state_q <= SYNC;
      endcase
    end
  end
endmodule

// File: rtl/tqvp_cattuto_ws2812b_receiver.sv
// tqvp_cattuto_ws2812b_receiver: TinyQV WS2812B sniffer capturing the GRB word at a CPU-selected LED index.
// Define WS2812B_RX_FWD_EN to pass every LED after the first out on uo_out[1].
module tqvp_cattuto_ws2812b_receiver
  import ws2812b_pkg::*;
#(
  parameter int RX_PIN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);
  logic line, bit_valid, bit_val, glitch, frame_end, busy;
  logic [7:0] g_q, r_q, b_q, idx_q, count_q, word_q, word_d;
  logic [4:0] bit_q, bit_d;
  logic [22:0] shift_q, shift_d;
  logic new_q, new_d, done_q, done_d, err_q, err_d;
  logic [23:0] word;
  logic word_done, hit, wr_st, unused_w;
  ws2812b_rx_bitdec u_bitdec (
    .clk(clk), .rst_n(rst_n), .rx_i(ui_in[RX_PIN]), .line_o(line), .bit_valid_o(bit_valid),
    .bit_val_o(bit_val), .glitch_o(glitch), .frame_end_o(frame_end), .busy_o(busy)
  );
  assign word = {shift_q, bit_val};
  assign word_done = bit_valid && bit_q == 5'd23;
  assign hit = word_done && word_q == idx_q;
  assign wr_st = data_write && address == ADDR_STATUS;
  // Hardware set wins over a same-cycle CPU clear.
  always_comb begin
    shift_d = frame_end ? '0 : bit_valid ? (word_done ? '0 : word[22:0]) : shift_q;
    bit_d = frame_end ? '0 : bit_valid ? (word_done ? '0 : bit_q + 5'd1) : bit_q;
    word_d = frame_end ? '0 : (word_done && word_q != 8'hff) ? word_q + 8'd1 : word_q;
    new_d = (new_q & ~(wr_st & data_in[ST_NEW])) | hit;
    done_d = (done_q & ~(wr_st & data_in[ST_DONE])) | frame_end;
    err_d = (err_q & ~(wr_st & data_in[ST_ERR])) | glitch | (frame_end && bit_q != '0);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {g_q, r_q, b_q, idx_q, count_q, word_q, bit_q, shift_q} <= '0;
      {new_q, done_q, err_q} <= '0;
    end else begin
      {word_q, bit_q, shift_q} <= {word_d, bit_d, shift_d};
      {new_q, done_q, err_q} <= {new_d, done_d, err_d};
      if (hit) {g_q, r_q, b_q} <= word;
      if (data_write && address == ADDR_IDX) idx_q <= data_in;
      if (frame_end) count_q <= word_q;
    end
  end
  always_comb begin
    case (address)
      ADDR_STATUS: data_out = {4'b0, busy, err_q, done_q, new_q};
      ADDR_G:      data_out = g_q;
      ADDR_R:      data_out = r_q;
      ADDR_B:      data_out = b_q;
      ADDR_IDX:    data_out = idx_q;
      ADDR_COUNT:  data_out = count_q;
      default:     data_out = '0;
    endcase
  end
`ifdef WS2812B_RX_FWD_EN
  logic fwd_q;
  // Gate opens while the line is low after word 0, so no runt pulse leaks out.
  always_ff @(posedge clk) begin
    if (!rst_n || frame_end) fwd_q <= 1'b0;
    else if (word_done && word_q == '0) fwd_q <= 1'b1;
  end
  assign uo_out = {6'b0, fwd_q & line, 1'b0};
  assign unused_w = &{1'b0, ui_in};
`else
  assign uo_out = '0;
  assign unused_w = &{1'b0, ui_in, line};
`endif
endmodule
